div_const_pipe: RTL and testbench

DIV_CONST_PIPE -- requirements
Module: div_const_pipe

---
 rtl/div_const_pkg.sv | 43 ++++
 rtl/div_const_stage.sv | 26 ++
 rtl/div_const_pipe.sv | 142 ++++++++++++++
 tb/tb_div_const_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_const_pkg.sv
// Shared constants and elaboration-time helpers for the constant-divisor pipeline.
// DIV_CONST_REM_EN selects whether the remainder is carried to an out_r port.
package div_const_pkg;

`ifdef DIV_CONST_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int floor_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) > 1) r = i + 1;
    end
    return r;
  endfunction

  // Quotient never exceeds (2^W-1)/D, so its top floor_log2(D) bits are always zero.
  function automatic int calc_qw(input int w, input int d);
    return w - floor_log2(d);
  endfunction

  function automatic int calc_rw(input int d);
    return clog2(d);
  endfunction

  function automatic bit params_legal(input int w, input int d, input int chunk, input int tag_w);
    return (w >= 8) && (w <= 64) && (d >= 2) && (d <= 255) &&
           (chunk >= 1) && (chunk <= w) && ((w % chunk) == 0) && (tag_w >= 1);
  endfunction

endpackage

// File: rtl/div_const_stage.sv
// One CHUNK-bit long-division step by the constant D: shifts the next dividend
// chunk into the running remainder and produces one quotient digit.
module div_const_stage #(
  parameter int D     = 3,
  parameter int CHUNK = 4,
  parameter int RW    = 2
) (
  input  logic [RW-1:0]    r_in,
  input  logic [CHUNK-1:0] chunk_in,
  output logic [RW-1:0]    r_out,
  output logic [CHUNK-1:0] q_dig
);

  localparam int AW = RW + CHUNK;
  localparam logic [AW-1:0] DIV = AW'(D);

  logic [AW-1:0] acc;

  // r_in < D keeps the digit below 2^CHUNK, so both casts are lossless.
  always_comb begin
    acc   = {r_in, chunk_in};
    q_dig = CHUNK'(acc / DIV);
    r_out = RW'(acc % DIV);
  end

endmodule

// File: rtl/div_const_pipe.sv
// Pipelined unsigned divide by a constant D, CHUNK dividend bits per stage, with
// valid/ready handshakes and a sideband tag. DIV_CONST_REM_EN adds the out_r port.
module div_const_pipe
  import div_const_pkg::*;
#(
  parameter int W     = 16,
  parameter int D     = 3,
  parameter int CHUNK = 4,
  parameter int TAG_W = 4,
  localparam int QW   = calc_qw(W, D),
  localparam int RW   = calc_rw(D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_q,
`ifdef DIV_CONST_REM_EN
  output logic [RW-1:0]    out_r,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = W / CHUNK;

  if (!params_legal(W, D, CHUNK, TAG_W)) begin : g_bad_params
    $error("div_const_pipe: illegal parameters W=%0d D=%0d CHUNK=%0d", W, D, CHUNK);
  end

  logic [S-1:0] v_vec;
  logic [S-1:0] en;
  logic         full;

  // Stage s may load when any stage from s to the output is empty, or the output retires.
  always_comb begin
    full = 1'b1;
    en   = '0;
    for (int s = S - 1; s >= 0; s--) begin
      full  = full & v_vec[s];
      en[s] = out_ready | ~full;
    end
  end

  assign in_ready = en[0];

  for (genvar s = 0; s < S; s++) begin : g_stage
    logic             v_src;
    logic [W-1:0]     x_src;
    logic [RW-1:0]    r_src;
    logic [QW-1:0]    q_src;
    logic [TAG_W-1:0] tag_src;
    logic [RW-1:0]    step_r;
    logic [CHUNK-1:0] step_q;
    logic             load;
    logic             v_q, v_d;
    logic [QW-1:0]    q_q, q_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    if (s == 0) begin : g_head
      assign v_src   = in_valid;
      assign x_src   = in_x;
      assign r_src   = '0;
      assign q_src   = '0;
      assign tag_src = in_tag;
    end else begin : g_body
      assign v_src   = g_stage[s-1].v_q;
      assign x_src   = g_stage[s-1].g_x.x_q;
      assign r_src   = g_stage[s-1].g_r.r_q;
      assign q_src   = g_stage[s-1].q_q;
      assign tag_src = g_stage[s-1].tag_q;
    end

    div_const_stage #(
      .D     (D),
      .CHUNK (CHUNK),
      .RW    (RW)
    ) u_step (
      .r_in     (r_src),
      .chunk_in (x_src[W-1 -: CHUNK]),
      .r_out    (step_r),
      .q_dig    (step_q)
    );

    assign load     = en[s] & v_src;
    assign v_vec[s] = v_q;

    always_comb begin
      v_d   = en[s] ? v_src : v_q;
      q_d   = load ? QW'({q_src, step_q}) : q_q;
      tag_d = load ? tag_src : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        q_q   <= '0;
        tag_q <= '0;
      end else begin
        v_q   <= v_d;
        q_q   <= q_d;
        tag_q <= tag_d;
      end
    end

    if (s < S - 1) begin : g_x
      logic [W-1:0] x_q, x_d;

      always_comb x_d = load ? (x_src << CHUNK) : x_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) x_q <= '0;
        else        x_q <= x_d;
      end
    end else begin : g_tail
      logic unused_tail;
      assign unused_tail = ^{x_src, step_r};
    end

    if ((s < S - 1) || REM_EN) begin : g_r
      logic [RW-1:0] r_q, r_d;

      always_comb r_d = load ? step_r : r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= r_d;
      end
    end
  end

  assign out_valid = g_stage[S-1].v_q;
  assign out_q     = g_stage[S-1].q_q;
  assign out_tag   = g_stage[S-1].tag_q;
`ifdef DIV_CONST_REM_EN
  assign out_r     = g_stage[S-1].g_r.r_q;
`endif

endmodule

// File: tb/tb_div_const_pipe.sv
// Self-checking bench for div_const_pipe: a W=16/D=3 instance against a queue
// model plus literal vectors, and a W=32/D=7/CHUNK=8 instance with literal vectors.
module tb_div_const_pipe;

  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_x;
  logic [3:0]  in_tag, out_tag;
  logic [14:0] out_q;
`ifdef DIV_CONST_REM_EN
  logic [1:0]  out_r;
`endif

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_x;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [29:0] b_out_q;
`ifdef DIV_CONST_REM_EN
  logic [2:0]  b_out_r;
`endif

  div_const_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
`ifdef DIV_CONST_REM_EN
    .out_r     (out_r),
`endif
    .out_tag   (out_tag)
  );

  div_const_pipe #(.W(32), .D(7), .CHUNK(8), .TAG_W(4)) u_dut_w32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_x      (b_in_x),
    .in_tag    (b_in_tag),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_q     (b_out_q),
`ifdef DIV_CONST_REM_EN
    .out_r     (b_out_r),
`endif
    .out_tag   (b_out_tag)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  typedef struct packed {
    logic [14:0] q;
    logic [1:0]  r;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          acc_cnt = 0, ret_cnt = 0, first_ret = 0, last_ret = 0;
  logic        held = 1'b0;
  logic [14:0] held_q;
  logic [3:0]  held_tag;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: every accepted operand must come back, in order, as x/3 and x%3.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_q", out_q, held_q);
        chk("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("model_q", out_q, e.q);
          chk("model_tag", out_tag, e.tag);
`ifdef DIV_CONST_REM_EN
          chk("model_r", out_r, e.r);
`endif
          if (ret_cnt == 0) first_ret = cyc;
          ret_cnt++;
          last_ret = cyc;
        end
      end
      held     = out_valid && !out_ready;
      held_q   = out_q;
      held_tag = out_tag;
      if (in_valid && in_ready) begin
        e.q   = 15'(in_x / 16'd3);
        e.r   = 2'(in_x % 16'd3);
        e.tag = in_tag;
        exp_q.push_back(e);
        acc_cnt++;
      end
    end
  end

  task automatic lat_a(input logic [15:0] x, input logic [3:0] tag,
                       input logic [14:0] eq, input logic [1:0] er);
    chk("lat_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = tag;
    for (int k = 1; k <= S; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
      if (k < S) chk("lat_early_valid", out_valid, 0);
    end
    chk("lat_valid", out_valid, 1);
    chk("lat_q", out_q, eq);
    chk("lat_tag", out_tag, tag);
`ifdef DIV_CONST_REM_EN
    chk("lat_r", out_r, er);
`else
    if (er > 2'd2) $display("note: remainder %0d outside D=3 range", er);
`endif
  endtask

  task automatic lat_b(input logic [31:0] x, input logic [3:0] tag,
                       input logic [29:0] eq, input logic [2:0] er);
    chk("w32_in_ready", b_in_ready, 1);
    b_in_valid = 1'b1;
    b_in_x     = x;
    b_in_tag   = tag;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) b_in_valid = 1'b0;
      if (k < 4) chk("w32_early_valid", b_out_valid, 0);
    end
    chk("w32_valid", b_out_valid, 1);
    chk("w32_q", b_out_q, eq);
    chk("w32_tag", b_out_tag, tag);
`ifdef DIV_CONST_REM_EN
    chk("w32_r", b_out_r, er);
`else
    if (er > 3'd6) $display("note: remainder %0d outside D=7 range", er);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [15:0] ops [14];
  int          idx;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_x = '0; b_in_tag = '0; b_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) ops[i] = 16'($urandom);

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_tag", out_tag, 0);
`ifdef DIV_CONST_REM_EN
    chk("rst_out_r", out_r, 0);
`endif
    chk("rst_w32_out_valid", b_out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);

    @(posedge clk); #1; lat_a(16'd100, 4'd5, 15'd33, 2'd1);
    @(posedge clk); #1; lat_a(16'd65535, 4'd6, 15'd21845, 2'd0);
    @(posedge clk); #1; lat_a(16'd0, 4'd7, 15'd0, 2'd0);
    @(posedge clk); #1; lat_b(32'hFFFF_FFFF, 4'd3, 30'd613566756, 3'd3);
    @(posedge clk); #1; lat_b(32'd0, 4'd4, 30'd0, 3'd0);

    // Back-to-back stream with the consumer always ready.
    ret_cnt = 0; acc_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_x     = (i == 0) ? 16'hFFFF : (i == 1) ? 16'd2 : 16'($urandom);
      in_tag   = 4'(i);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 30 && ret_cnt < 100; c++) begin
      @(posedge clk); #1;
    end
    chk("burst_accepts", acc_cnt, 100);
    chk("burst_retires", ret_cnt, 100);
    chk("burst_rate", last_ret - first_ret, 99);

    // Backpressure: consumer stalls for 10 cycles while the producer keeps offering.
    @(posedge clk); #1;
    out_ready = 1'b0; ret_cnt = 0; acc_cnt = 0; idx = 0;
    for (int c = 0; c < 26; c++) begin
      if (c == 10) out_ready = 1'b1;
      if (idx < 14) begin
        in_valid = 1'b1; in_x = ops[idx]; in_tag = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      if (c == 9) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_fill", acc_cnt, S);
        chk("bp_out_valid", out_valid, 1);
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && ret_cnt < 14; c++) begin
      @(posedge clk); #1;
    end
    chk("bp_no_loss", ret_cnt, 14);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with three operands in flight, then an accept right after release.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = ops[i]; in_tag = 4'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rm_valid_before", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_out_valid", out_valid, 0);
    chk("rm_out_q", out_q, 0);
    chk("rm_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lat_a(16'd200, 4'd9, 15'd66, 2'd2);
    repeat (3) @(posedge clk);
    #1 chk("rm_no_stale", exp_q.size(), 0);
    chk("rm_idle_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
